revaluate_stage: RTL and testbench
==================================

Name: revaluate_stage

Overview:
Downstream neighbour of the permute datapath. Consumes the 64 permuted 25-bit slices of one state, one per cycle over a valid/ready handshake. Applies the row-wise nonlinear revaluate (chi) step: out[x,y] = in[x,y] ^ (~in[x+1,y] & in[x+2,y]), with x+1 and x+2 taken mod 5. Writes each result slice to the slice memory at its slice index, then pulses done to the top-level controller.

Parameters:
W, 25, slice width in bits; fixed at 25 (5x5).
SLICES, 64, slices per state (lane length).
ADDR_W, 6, slice address width; equals log2(SLICES).

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  asynchronous, active-low reset; 0 resets all state immediately.
start  input  1  one-cycle pulse that begins processing of one state; ignored unless idle.
in_valid  input  1  upstream (permute DP) slice valid.
in_slice  input  W  permuted slice. Bit index is 5*y + x, with x, y in 0..4.
in_ready  output  1  stage can accept a slice this cycle.
out_we  output  1  slice memory write enable, one cycle per slice.
out_addr  output  ADDR_W  slice memory write address; equals the slice index.
out_slice  output  W  revaluated slice.
busy  output  1  high from the cycle after start until done.
done  output  1  one-cycle pulse after the last write.

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; slice counter = 0; output register = 0.
  - in_ready=0, out_we=0, out_addr=0, out_slice=0, busy=0, done=0.
  - Reset mid-operation aborts the current state immediately. No further writes occur; any partial memory contents are left as they are.
- FSM states: IDLE, RUN, FLUSH, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - in_valid is ignored.
  - start=1 moves to RUN and clears the counter.
- RUN:
  - in_ready=1, busy=1.
  - An accept is a cycle with in_valid & in_ready. On each accept:
    - chi of in_slice is registered into out_slice;
    - out_addr takes the counter value;
    - out_we=1 on the next cycle;
    - the counter increments.
  - Latency is exactly 1 cycle from accept to write. Throughput is 1 slice/cycle.
  - in_valid=0 stalls the stage: no write on the following cycle and the counter holds. Gaps of any length are legal.
  - The accept at counter=SLICES-1 moves to FLUSH. in_ready falls in the same clock edge, so a 65th slice is never accepted.
- FLUSH:
  - in_ready=0, busy=1.
  - out_we=1 for the final slice (address 63).
  - Next state is DONE.
- DONE:
  - done=1 for exactly one cycle; busy=0 in this cycle.
  - Next state is IDLE.
- out_we is 0 in every cycle that does not follow an accept.
- out_slice and out_addr hold their last values when out_we=0.
- start while busy or in DONE is ignored; it does not restart the stage.
- start and in_valid in the same cycle in IDLE: only start takes effect. The slice is not accepted because in_ready=0.
- Counter is ADDR_W bits. Its terminal value is SLICES-1; it never wraps within a state. It is cleared to 0 on the next start.
- Arithmetic: pure bitwise, mod-5 column indexing within each row, no carries.

Decomposition:
- Shared package holds:
  - constants W=25, SLICES=64, ADDR_W=6, ROW=5;
  - the FSM state encoding (IDLE=2'd0, RUN=2'd1, FLUSH=2'd2, DONE=2'd3);
  - the bit-index helper 5*y+x.
- One sub-module, chi_row: combinational, 5-bit in, 5-bit out, implementing out[x] = in[x] ^ (~in[(x+1)%5] & in[(x+2)%5]).
- revaluate_stage instantiates chi_row 5 times via generate, one instance per row y. Control (FSM, counter, output register) stays in the top module.

Test Plan:
- Reset check: hold rst=0 mid-RUN after 10 accepts -> all outputs 0 immediately. After release, no out_we until a new start; the next run writes addresses 0..63 from scratch.
- Streaming run: start, then in_valid=1 continuously with slice k = 25'h0 for all k -> exactly 64 out_we pulses, addr 0..63 in order, each out_slice=25'h0000000. done pulses 66 cycles after start (64 accepts + FLUSH + DONE). in_ready=0 after the 64th accept.
- Single bit: in_slice=25'h0000001 (x=0,y=0) -> out_slice=25'h0000009 one cycle later. Bits x=0 and x=3 are set.
- Row pattern and all-ones:
  - in_slice=25'h0000002 (x=1,y=0) -> 25'h0000012.
  - in_slice=25'h1FFFFFF -> 25'h1FFFFFF.
  - in_slice=25'h0000002<<20 (row y=4) -> 25'h0000012<<20, confirming row independence.
- Stalls: in_valid toggles 1,0,0,1,... across a full state -> out_we only on cycles following accepts; addresses contiguous 0..63; exactly one done.
- Illegal events: start pulsed at slice 30 and in_valid held high in IDLE/DONE -> run continues unaffected, no extra writes, no 65th accept, single done pulse.

Source files
------------

// File: rtl/revaluate_stage_pkg.sv
// Shared constants, FSM state encoding and the slice bit-index helper for the
// revaluate (chi) stage.
package revaluate_stage_pkg;

    localparam int W      = 25;  // slice width, one 5x5 plane
    localparam int SLICES = 64;  // slices per state (lane length)
    localparam int ADDR_W = 6;   // log2(SLICES)
    localparam int ROW    = 5;   // bits per row

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Position of lane (x, y) inside a slice.
    function automatic int bit_idx(input int x, input int y);
        return ROW * y + x;
    endfunction

endpackage

// File: rtl/chi_row.sv
// One row of the revaluate (chi) step: out[x] = in[x] ^ (~in[x+1] & in[x+2]),
// with the column indices wrapping mod 5.
module chi_row
    import revaluate_stage_pkg::*;
(
    input  logic [ROW-1:0] row_in,
    output logic [ROW-1:0] row_out
);

    // Purely bitwise nonlinear mix of each column with its two right neighbours.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, so no path leaves it unassigned and no latch is inferred.
        row_out = '0;
        for (int x = 0; x < ROW; x++) begin
            row_out[x] = row_in[x] ^ (~row_in[(x + 1) % ROW] & row_in[(x + 2) % ROW]);
        end
    end

endmodule

// File: rtl/revaluate_stage.sv
// Revaluate stage: accepts the 64 permuted slices of one state over a
// valid/ready handshake, applies chi row-wise, and writes each result to the
// slice memory one cycle after it was accepted. Pulses done at the end.
module revaluate_stage
    import revaluate_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    input  logic [W-1:0]      in_slice,
    output logic              in_ready,
    output logic              out_we,
    output logic [ADDR_W-1:0] out_addr,
    output logic [W-1:0]      out_slice,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(SLICES - 1);

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] cnt;
    logic [W-1:0]      chi_slice;
    logic              accept;
    logic              last;

    // Rows are independent, so chi is five copies of the row function.
    generate
        for (genvar y = 0; y < ROW; y++) begin : g_row
            chi_row u_chi_row (
                .row_in  (in_slice[bit_idx(0, y) +: ROW]),
                .row_out (chi_slice[bit_idx(0, y) +: ROW])
            );
        end
    endgenerate

    assign accept = in_valid & in_ready;
    assign last   = (cnt == LAST);

    // FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples the pre-edge values, independent of statement order.
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and Moore outputs; in_ready drops on the edge of the last accept.
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (accept && last) begin
                    state_next = FLUSH;
                end
            end
            FLUSH: begin
                busy       = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Slice counter: cleared by an accepted start, stops at the terminal index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (state == IDLE && start) begin
            cnt <= '0;
        end else if (accept && !last) begin
            cnt <= cnt + ADDR_W'(1);
        end
    end

    // Write port register: one-cycle latency from accept to write, holds otherwise.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_we    <= 1'b0;
            out_addr  <= '0;
            out_slice <= '0;
        end else begin
            out_we <= accept;
            if (accept) begin
                out_addr  <= cnt;
                out_slice <= chi_slice;
            end
        end
    end

endmodule

// File: tb/tb_revaluate_stage.sv
// Self-checking bench for revaluate_stage: randomized slices and valid
// patterns against a transaction-level reference built from the chi rule.
module tb_revaluate_stage;
    import revaluate_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic              in_valid = 1'b0;
    logic [W-1:0]      in_slice = '0;
    logic              in_ready;
    logic              out_we;
    logic [ADDR_W-1:0] out_addr;
    logic [W-1:0]      out_slice;
    logic              busy;
    logic              done;

    int n_checks = 0;
    int n_errors = 0;

    // Expected held contents of the write port.
    logic [ADDR_W-1:0] exp_addr = '0;
    logic [W-1:0]      exp_slice = '0;

    logic [W-1:0] dir_in  [4];
    logic [W-1:0] dir_out [4];

    revaluate_stage dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .in_valid  (in_valid),
        .in_slice  (in_slice),
        .in_ready  (in_ready),
        .out_we    (out_we),
        .out_addr  (out_addr),
        .out_slice (out_slice),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference chi on a 5x5 plane: a[x][y] ^ (~a[x+1][y] & a[x+2][y]).
    function automatic logic [W-1:0] chi_ref(input logic [W-1:0] s);
        logic [W-1:0] r;
        logic         a [5][5];
        r = '0;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                a[x][y] = s[5 * y + x];
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                r[5 * y + x] = a[x][y] ^ (~a[(x + 1) % 5][y] & a[(x + 2) % 5][y]);
        return r;
    endfunction

    function automatic logic [W-1:0] pick_data(input int dmode, input int idx);
        if (dmode == 0) return '0;
        if (dmode == 1 && idx < 4) return dir_in[idx];
        return W'($urandom);
    endfunction

    // Asynchronous reset mid-run: outputs clear at once, stage stays idle after release.
    task automatic do_abort(input string name);
        #1 rst = 1'b0;
        #1;
        check({name, ".rst_we"},    32'(out_we),    32'd0);
        check({name, ".rst_ready"}, 32'(in_ready),  32'd0);
        check({name, ".rst_busy"},  32'(busy),      32'd0);
        check({name, ".rst_done"},  32'(done),      32'd0);
        check({name, ".rst_addr"},  32'(out_addr),  32'd0);
        check({name, ".rst_slice"}, 32'(out_slice), 32'd0);
        exp_addr  = '0;
        exp_slice = '0;
        start     = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        in_valid = 1'b1;
        in_slice = W'($urandom);
        @(negedge clk);
        repeat (4) begin
            @(negedge clk);
            check({name, ".idle_we"},    32'(out_we),   32'd0);
            check({name, ".idle_ready"}, 32'(in_ready), 32'd0);
            check({name, ".idle_busy"},  32'(busy),     32'd0);
        end
        in_valid = 1'b0;
    endtask

    // One state: start, feed slices under a valid pattern, check every cycle.
    // vmode: 0 always valid, 1 pattern 1,0,0, 2 random.
    task automatic run_state(input string name, input int vmode, input int dmode,
                             input bit noisy, input bit start_mid, input int abort_at);
        int           acc = 0;
        int           post = 0;
        int           cyc = 0;
        int           writes = 0;
        int           dones = 0;
        int           done_cyc = -1;
        bit           prev_acc = 1'b0;
        bit           drive_v;
        logic [W-1:0] prev_s = '0;

        start    = 1'b1;
        in_valid = noisy;
        in_slice = W'($urandom);
        @(negedge clk);
        start = 1'b0;

        while (cyc < 1000) begin
            cyc++;
            if (acc == SLICES) post++;
            if (prev_acc) begin
                exp_addr  = ADDR_W'(acc - 1);
                exp_slice = chi_ref(prev_s);
            end
            check({name, ".we"},    32'(out_we),    32'(prev_acc));
            check({name, ".ready"}, 32'(in_ready),  32'(acc < SLICES));
            check({name, ".busy"},  32'(busy),      32'(acc < SLICES || post == 1));
            check({name, ".done"},  32'(done),      32'(post == 2));
            check({name, ".addr"},  32'(out_addr),  32'(exp_addr));
            check({name, ".slice"}, 32'(out_slice), 32'(exp_slice));
            if (dmode == 1 && prev_acc && acc <= 4)
                check({name, ".directed"}, 32'(out_slice), 32'(dir_out[acc - 1]));
            if (out_we) writes++;
            if (done) begin
                dones++;
                done_cyc = cyc;
            end
            if (post == 3) break;
            if (abort_at > 0 && acc == abort_at) begin
                do_abort(name);
                return;
            end

            if (acc < SLICES) begin
                case (vmode)
                    0:       drive_v = 1'b1;
                    1:       drive_v = ((cyc % 3) == 1);
                    default: drive_v = 1'($urandom_range(0, 1));
                endcase
            end else begin
                drive_v = noisy;
            end
            in_valid = drive_v;
            in_slice = pick_data(dmode, acc);
            start    = start_mid && (acc == 30);
            prev_acc = drive_v && (acc < SLICES);
            if (prev_acc) begin
                prev_s = in_slice;
                acc++;
            end
            @(negedge clk);
        end

        start    = 1'b0;
        in_valid = 1'b0;
        check({name, ".timeout"}, 32'(post == 3), 32'd1);
        check({name, ".writes"},  32'(writes),    32'(SLICES));
        check({name, ".dones"},   32'(dones),     32'd1);
        if (vmode == 0)
            check({name, ".done_cycle"}, 32'(done_cyc), 32'd66);
    endtask

    initial begin
        dir_in[0]  = 25'h0000001;  dir_out[0] = 25'h0000009;
        dir_in[1]  = 25'h0000002;  dir_out[1] = 25'h0000012;
        dir_in[2]  = 25'h1FFFFFF;  dir_out[2] = 25'h1FFFFFF;
        dir_in[3]  = 25'h0000002 << 20;
        dir_out[3] = 25'h0000012 << 20;

        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset.we",    32'(out_we),    32'd0);
        check("reset.ready", 32'(in_ready),  32'd0);
        check("reset.busy",  32'(busy),      32'd0);
        check("reset.done",  32'(done),      32'd0);
        check("reset.addr",  32'(out_addr),  32'd0);
        check("reset.slice", 32'(out_slice), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        run_state("stream",   0, 0, 1'b0, 1'b0, 0);
        run_state("directed", 0, 1, 1'b0, 1'b0, 0);
        run_state("stall",    1, 2, 1'b0, 1'b0, 0);
        run_state("abort",    2, 2, 1'b0, 1'b0, 10);
        run_state("rerun",    2, 2, 1'b1, 1'b0, 0);
        run_state("illegal",  2, 2, 1'b1, 1'b1, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
